// File: rtl/reg_file.sv
// Register file with a registered read port and write-wins collision.
// Define REG_FILE_RDVALID_EN to add the read_valid strobe output.
module reg_file #(
  parameter int ADDR_WIDTH = 3,
  parameter int RF_DEPTH   = 8,
  parameter int RF_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [RF_WIDTH-1:0]   write_data,
`ifdef REG_FILE_RDVALID_EN
  output logic                  read_valid,
`endif
  output logic [RF_WIDTH-1:0]   read_data
);

  logic [RF_WIDTH-1:0] mem_q [RF_DEPTH];
  logic [RF_WIDTH-1:0] mem_d [RF_DEPTH];
  logic [RF_WIDTH-1:0] rd_q;
  logic [RF_WIDTH-1:0] rd_d;
  logic                rd_acc;

  // A read is taken only when no write competes for the cycle.
  assign rd_acc = read_enable & ~write_enable;

  // Next storage state; addresses past the last word match nothing.
  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (write_enable &&
          address == i[ADDR_WIDTH-1:0]) begin
        mem_d[i] = write_data;
      end
    end
  end

  // Read mux; an out-of-range address yields zero.
  always_comb begin
    rd_d = rd_q;
    if (rd_acc) begin
      rd_d = '0;
      for (int i = 0; i < RF_DEPTH; i++) begin
        if (address == i[ADDR_WIDTH-1:0]) begin
          rd_d = mem_q[i];
        end
      end
    end
  end

  // Storage and read register, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_q <= rd_d;
    end
  end

  assign read_data = rd_q;

`ifdef REG_FILE_RDVALID_EN
  logic rv_q;

  // One-cycle strobe following each accepted read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rv_q <= 1'b0;
    end else begin
      rv_q <= rd_acc;
    end
  end

  assign read_valid = rv_q;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file (RF_DEPTH=6 to reach out-of-range).
// Table vectors, random traffic vs an array model, async reset case.
module tb_reg_file;

  localparam int AW = 3;
  localparam int DP = 6;
  localparam int W  = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] address = '0;
  logic          write_enable = 1'b0;
  logic          read_enable = 1'b0;
  logic [W-1:0]  write_data = '0;
  logic [W-1:0]  read_data;
`ifdef REG_FILE_RDVALID_EN
  logic          read_valid;
`endif

  int tests = 0;
  int fails = 0;

  reg_file #(
    .ADDR_WIDTH(AW),
    .RF_DEPTH  (DP),
    .RF_WIDTH  (W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .address     (address),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .write_data  (write_data),
`ifdef REG_FILE_RDVALID_EN
    .read_valid  (read_valid),
`endif
    .read_data   (read_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         we;
    logic         re;
    int           addr;
    int           wd;
    int           exp_rd;
    logic         exp_v;
  } vec_t;

  vec_t vecs[$];
  int   model[8];
  int   last_rd;

  task automatic check(input string nm, input int act,
                       input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_v(input string nm, input logic exp);
`ifdef REG_FILE_RDVALID_EN
    tests++;
    if (read_valid !== exp) begin
      fails++;
      $display("FAIL %s: read_valid got %b expected %b",
               nm, read_valid, exp);
    end
`else
    if (exp === 1'bz) $display("unused %s", nm);
`endif
  endtask

  task automatic drive(input logic we, input logic re,
                       input int a, input int d);
    write_enable = we;
    read_enable  = re;
    address      = a[AW-1:0];
    write_data   = d[W-1:0];
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(logic we, logic re, int a,
                              int d, int e);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wd = d;
    v.exp_rd = e; v.exp_v = re & ~we;
    return v;
  endfunction

  initial begin
    // reset state
    for (int a = 0; a < 8; a++) vecs.push_back(mk(0, 1, a, 0, 0));
    vecs.push_back(mk(1, 0, 2, 22, 0));
    vecs.push_back(mk(1, 0, 3, 23, 0));
    vecs.push_back(mk(0, 1, 2, 0, 22));
    vecs.push_back(mk(0, 1, 3, 0, 23));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 1, 9, 23));
    vecs.push_back(mk(0, 1, 2, 0, 22));
    vecs.push_back(mk(1, 1, 5, 99, 22));
    vecs.push_back(mk(0, 1, 5, 0, 99));
    vecs.push_back(mk(1, 0, 6, 77, 99));
    vecs.push_back(mk(0, 1, 6, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 22));
    vecs.push_back(mk(0, 1, 3, 0, 23));
    vecs.push_back(mk(0, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 99));
    vecs.push_back(mk(1, 0, 7, 55, 99));
    vecs.push_back(mk(0, 1, 7, 0, 0));

    #7;
    check("reset_rd", int'(read_data), 0);
    check_v("reset_v", 1'b0);
    #3;
    RST = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d", i), int'(read_data),
            vecs[i].exp_rd);
      check_v($sformatf("vec%0d_v", i), vecs[i].exp_v);
    end

    // model state after the table
    for (int a = 0; a < 8; a++) model[a] = 0;
    model[2] = 22; model[3] = 23; model[5] = 99;
    last_rd = 0;

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic we, re;
      int a, d;
      logic ev;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 7);
      d  = $urandom_range(0, 65535);
      ev = 1'b0;
      drive(we, re, a, d);
      if (we) begin
        if (a < DP) model[a] = d;
      end else if (re) begin
        last_rd = (a < DP) ? model[a] : 0;
        ev = 1'b1;
      end
      check($sformatf("rnd%0d", n), int'(read_data), last_rd);
      check_v($sformatf("rnd%0d_v", n), ev);
    end

    // async reset in the middle of a pending write
    drive(1, 0, 4, 44);
    drive(0, 1, 4, 0);
    check("pre_rst_rd4", int'(read_data), 44);
    check_v("pre_rst_v", 1'b1);
    write_enable = 1'b1;
    read_enable  = 1'b0;
    address      = 3'd1;
    write_data   = 16'd5;
    #3;
    RST = 1'b1;
    #1;
    check("rst_async_rd", int'(read_data), 0);
    check_v("rst_async_v", 1'b0);
    read_enable = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_hold_rd", int'(read_data), 0);
    check_v("rst_hold_v", 1'b0);
    #3;
    RST = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    drive(0, 1, 4, 0);
    check("post_rst_rd4", int'(read_data), 0);
    check_v("post_rst_v", 1'b1);
    drive(0, 1, 1, 0);
    check("post_rst_rd1", int'(read_data), 0);
    drive(1, 0, 4, 444);
    drive(0, 1, 4, 0);
    check("post_rst_wr4", int'(read_data), 444);
    drive(0, 0, 0, 0);
    check("post_rst_hold", int'(read_data), 444);
    check_v("post_rst_idle_v", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
